// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: IF/ID stage register layout and fetch FSM states.
package rv32i_types;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } IF_ID_stage_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Instruction fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/i_fetch_if.sv
// Instruction memory request/response port: one outstanding single-word read.
interface i_fetch_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    modport master (output imem_read, output imem_address,
                    input  imem_resp, input  imem_rdata);
    modport slave  (input  imem_read, input  imem_address,
                    output imem_resp, output imem_rdata);
endinterface

// File: rtl/i_fetch.sv
// IF stage: PC, one-entry stall buffer and redirect squashing, feeding the IF/ID register.
module i_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h40000060
) (
    input  logic          clk,
    input  logic          rst,
    i_fetch_if.master     imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output IF_ID_stage_t  if_out
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    IF_ID_stage_t if_out_q, if_out_d;
    logic [31:0]  redir_pc;

    assign redir_pc          = word_align(redirect_pc);
    assign imem.imem_address = fetch_pc_q;
    assign imem.imem_read    = !rst && (state_q != HOLD);
    assign if_out            = if_out_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        target_d     = target_q;
        hold_instr_d = hold_instr_q;
        if_out_d     = if_out_q;

        if (redirect) begin
            if_out_d.valid = 1'b0;
        end else if (!stall && !(state_q == REQ && imem.imem_resp) && state_q != HOLD) begin
            if_out_d.valid = 1'b0;
        end

        unique case (state_q)
            REQ: begin
                if (redirect) begin
                    // Address must stay stable while a request is outstanding.
                    if (imem.imem_resp) fetch_pc_d = redir_pc;
                    else begin
                        target_d = redir_pc;
                        state_d  = DROP;
                    end
                end else if (imem.imem_resp) begin
                    if (!stall) begin
                        if_out_d   = '{pc: fetch_pc_q, instr: imem.imem_rdata, valid: 1'b1};
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    state_d    = REQ;
                end else if (!stall) begin
                    if_out_d   = '{pc: fetch_pc_q, instr: hold_instr_q, valid: 1'b1};
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = REQ;
                end
            end
            DROP: begin
                if (imem.imem_resp) begin
                    fetch_pc_d = redirect ? redir_pc : target_q;
                    state_d    = REQ;
                end else if (redirect) begin
                    target_d = redir_pc;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            target_q     <= '0;
            hold_instr_q <= '0;
            if_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            target_q     <= target_d;
            hold_instr_q <= hold_instr_d;
            if_out_q     <= if_out_d;
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: hand-driven memory responses, checks taken 1ns after each edge.
module tb_i_fetch;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    IF_ID_stage_t if_out;
    int           checks   = 0;
    int           failures = 0;

    i_fetch_if imem();

    i_fetch #(.RESET_PC(32'h40000060)) dut (
        .clk(clk), .rst(rst), .imem(imem.master), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_out(if_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ent(input logic [31:0] pc, input logic [31:0] instr);
        return {pc, instr, 1'b1};
    endfunction

    task automatic bus(input string tag, input logic rd, input logic [31:0] addr);
        chk({tag, ".read"}, 65'(imem.imem_read), 65'(rd));
        chk({tag, ".addr"}, 65'(imem.imem_address), 65'(addr));
    endtask

    task automatic vld0(input string tag);
        chk({tag, ".valid"}, 65'(if_out.valid), 65'd0);
    endtask

    task automatic resp(input logic r, input logic [31:0] d);
        imem.imem_resp  = r;
        imem.imem_rdata = d;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        resp(1'b0, '0);
        cyc(); cyc();
        chk("reset.if_out", 65'(if_out), 65'd0);
        bus("reset", 1'b0, 32'h40000060);
        rst = 1'b0; #1;

        // latency 1, no stall
        bus("l1.c0", 1'b1, 32'h40000060);
        cyc();                          bus("l1.c1", 1'b1, 32'h40000060);
        resp(1'b1, 32'h00000013); cyc(); chk("l1.i0", 65'(if_out), ent(32'h40000060, 32'h00000013));
        bus("l1.c2", 1'b1, 32'h40000064);
        resp(1'b0, '0); cyc();          vld0("l1.bubble"); bus("l1.c3", 1'b1, 32'h40000064);
        resp(1'b1, 32'h00100093); cyc(); chk("l1.i1", 65'(if_out), ent(32'h40000064, 32'h00100093));
        bus("l1.c4", 1'b1, 32'h40000068);
        resp(1'b0, '0); cyc();          vld0("l1.bubble2");

        // restart, latency 3
        rst = 1'b1; cyc();
        chk("rst2.if_out", 65'(if_out), 65'd0);
        chk("rst2.read", 65'(imem.imem_read), 65'd0);
        rst = 1'b0; #1;
        for (int i = 1; i <= 3; i++) begin
            cyc(); bus("l3.wait", 1'b1, 32'h40000060); vld0("l3.wait");
        end
        resp(1'b1, 32'h00000013); cyc(); chk("l3.i0", 65'(if_out), ent(32'h40000060, 32'h00000013));
        bus("l3.next", 1'b1, 32'h40000064);

        // stall across a response
        stall = 1'b1; resp(1'b0, '0); cyc();
        chk("st.pre", 65'(if_out), ent(32'h40000060, 32'h00000013));
        resp(1'b1, 32'h00500093); cyc();
        resp(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            bus("st.hold", 1'b0, 32'h40000064);
            chk("st.keep", 65'(if_out), ent(32'h40000060, 32'h00000013));
            cyc();
        end
        stall = 1'b0;
        chk("st.keep3", 65'(if_out), ent(32'h40000060, 32'h00000013));
        cyc();
        chk("st.release", 65'(if_out), ent(32'h40000064, 32'h00500093));
        bus("st.next", 1'b1, 32'h40000068);

        // redirect one cycle into a latency-3 request at 0x...68
        cyc(); vld0("rd.c1");
        redirect = 1'b1; redirect_pc = 32'h40000100; cyc();
        redirect = 1'b0; bus("rd.drop", 1'b1, 32'h40000068); vld0("rd.drop");
        cyc(); bus("rd.drop2", 1'b1, 32'h40000068);
        resp(1'b1, 32'hDEADBEEF); cyc();
        vld0("rd.discard"); bus("rd.target", 1'b1, 32'h40000100);
        resp(1'b1, 32'h00100113); cyc();
        chk("rd.i", 65'(if_out), ent(32'h40000100, 32'h00100113));

        // redirect + stall while in HOLD
        stall = 1'b1; resp(1'b0, '0); cyc();
        resp(1'b1, 32'h12345678); cyc();
        resp(1'b0, '0); bus("hr.hold", 1'b0, 32'h40000104);
        redirect = 1'b1; redirect_pc = 32'h40000203; cyc();
        vld0("hr.squash"); bus("hr.target", 1'b1, 32'h40000200);
        redirect = 1'b0; stall = 1'b0; resp(1'b1, 32'h0000006F); cyc();
        chk("hr.i", 65'(if_out), ent(32'h40000200, 32'h0000006F));

        // reset mid-request
        resp(1'b0, '0); cyc();
        bus("mr.pending", 1'b1, 32'h40000204);
        rst = 1'b1; cyc();
        chk("mr.if_out", 65'(if_out), 65'd0);
        chk("mr.read", 65'(imem.imem_read), 65'd0);
        rst = 1'b0; #1;
        bus("mr.restart", 1'b1, 32'h40000060);
        resp(1'b1, 32'h0000AAAA); cyc();
        chk("mr.i", 65'(if_out), ent(32'h40000060, 32'h0000AAAA));

        // redirect coinciding with resp in REQ, then PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFE; resp(1'b1, 32'h0BADF00D); cyc();
        redirect = 1'b0; vld0("wr.redir"); bus("wr.redir", 1'b1, 32'hFFFFFFFC);
        resp(1'b1, 32'h00000013); cyc();
        chk("wr.i", 65'(if_out), ent(32'hFFFFFFFC, 32'h00000013));
        bus("wr.wrap", 1'b1, 32'h00000000);

        // DROP: second redirect overwrites the pending target
        resp(1'b0, '0); redirect = 1'b1; redirect_pc = 32'h00000300; cyc();
        redirect_pc = 32'h00000400; cyc();
        redirect = 1'b0; bus("dr.old", 1'b1, 32'h00000000);
        resp(1'b1, 32'hCAFEBABE); cyc();
        vld0("dr.discard"); bus("dr.target", 1'b1, 32'h00000400);
        resp(1'b1, 32'h00000033); cyc();
        chk("dr.i", 65'(if_out), ent(32'h00000400, 32'h00000033));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
